// File: rtl/uart.sv
// uart: loopback UART core with a transmitter, a receiver and a 16x baud
// generator, all in one clock domain. The TX line drives the RX input
// internally through a 2-flop synchronizer.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   baud_sel[1:0]          - 9600 / 19200 / 38400 / 115200
//   line_control_reg[4:0]  - [1:0] parity, [2] stop bits, [4:3] word length
//   data_input[7:0]        - word to send, LSB first
//   data_received[7:0]     - last received word, right-aligned
//   data_corrupted_flag    - last received frame had a parity or stop error
//   active_flag_rx/_tx     - receiver / transmitter inside a frame
//   transmission_done_flag - 1-cycle pulse at receive completion
//   done_flag_tx           - 1-cycle pulse on the last cycle of a TX frame
module uart #(
    parameter int unsigned CLK_HZ = 18_432_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] baud_sel,
    input  logic [4:0] line_control_reg,
    input  logic [7:0] data_input,
    output logic [7:0] data_received,
    output logic       data_corrupted_flag,
    output logic       active_flag_rx,
    output logic       transmission_done_flag,
    output logic       active_flag_tx,
    output logic       done_flag_tx
);
    localparam int unsigned CFG_W = 15;
    localparam int unsigned DIV_W = 7;
    localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(CLK_HZ / (16 * 9600));
    localparam logic [DIV_W-1:0] DIV_19200  = DIV_W'(CLK_HZ / (16 * 19200));
    localparam logic [DIV_W-1:0] DIV_38400  = DIV_W'(CLK_HZ / (16 * 38400));
    localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'(CLK_HZ / (16 * 115200));

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;

    state_e           tx_state_q, rx_state_q;
    logic [CFG_W-1:0] snap_q;
    logic [DIV_W-1:0] div_q, tx_div_q, rx_div_q;
    logic [3:0]       tx_tick_q, rx_tick_q;
    logic [2:0]       tx_bit_q, rx_bit_q;
    logic             tx_stop_q, rx_stop_q;
    logic             pending_q, tx_line_q;
    logic             rx_s1_q, rx_s2_q, rx_s3_q;
    logic [7:0]       rx_shift_q;
    logic             rx_par_err_q, rx_stop_err_q;

    // Snapshot fields: {baud, lcr, data}
    logic [CFG_W-1:0] cfg_c;
    logic [1:0]       snap_par_c, snap_wl_c;
    logic             snap_stop_c;
    logic [7:0]       snap_data_c, data_mask_c;
    logic [2:0]       last_bit_c, tx_next_bit_c;
    logic             par_even_c, tx_par_bit_c, rx_par_exp_c;
    logic             tx_tick_c, tx_bit_end_c, tx_last_cyc_next_c;
    logic             rx_tick_c, rx_sample_c, rx_fall_c, rx_stop_err_c;
    logic [DIV_W-1:0] sel_div_c;

    assign cfg_c         = {baud_sel, line_control_reg, data_input};
    assign snap_par_c    = snap_q[9:8];
    assign snap_stop_c   = snap_q[10];
    assign snap_wl_c     = snap_q[12:11];
    assign snap_data_c   = snap_q[7:0];
    assign data_mask_c   = 8'hFF >> snap_wl_c;
    assign last_bit_c    = 3'd7 - {1'b0, snap_wl_c};
    assign tx_next_bit_c = tx_bit_q + 3'd1;
    assign par_even_c    = ^(snap_data_c & data_mask_c);
    // Odd and inverted-even modes both transmit the complement of even parity
    assign tx_par_bit_c  = (snap_par_c == 2'b10) ? par_even_c : ~par_even_c;
    assign rx_par_exp_c  = (snap_par_c == 2'b01) ? ~(^rx_shift_q) : ^rx_shift_q;

    always_comb begin
        sel_div_c = DIV_9600;
        case (baud_sel)
            2'b01:   sel_div_c = DIV_19200;
            2'b10:   sel_div_c = DIV_38400;
            2'b11:   sel_div_c = DIV_115200;
            default: sel_div_c = DIV_9600;
        endcase
    end

    assign tx_tick_c          = (tx_div_q == div_q - DIV_W'(1));
    assign tx_bit_end_c       = tx_tick_c && (tx_tick_q == 4'd15);
    // One cycle before the bit ends, so the done pulse lands on its last cycle
    assign tx_last_cyc_next_c = (tx_div_q == div_q - DIV_W'(2)) && (tx_tick_q == 4'd15);

    assign rx_tick_c     = (rx_div_q == div_q - DIV_W'(1));
    // Start bit is sampled at its mid-point, every later bit 16 ticks on
    assign rx_sample_c   = rx_tick_c &&
                           (rx_tick_q == ((rx_state_q == ST_START) ? 4'd7 : 4'd15));
    assign rx_fall_c     = rx_s3_q & ~rx_s2_q;
    assign rx_stop_err_c = rx_stop_err_q | ~rx_s2_q;

    // Transmitter FSM and snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q     <= ST_IDLE;
            snap_q         <= '0;
            div_q          <= '0;
            tx_div_q       <= '0;
            tx_tick_q      <= '0;
            tx_bit_q       <= '0;
            tx_stop_q      <= 1'b0;
            pending_q      <= 1'b1;
            tx_line_q      <= 1'b1;
            active_flag_tx <= 1'b0;
            done_flag_tx   <= 1'b0;
        end else begin
            done_flag_tx <= 1'b0;
            if (tx_state_q != ST_IDLE) begin
                tx_div_q <= tx_tick_c ? '0 : tx_div_q + DIV_W'(1);
                if (tx_tick_c) tx_tick_q <= tx_tick_q + 4'd1;
            end
            case (tx_state_q)
                ST_IDLE: begin
                    tx_line_q <= 1'b1;
                    if (pending_q || (cfg_c != snap_q)) begin
                        snap_q         <= cfg_c;
                        div_q          <= sel_div_c;
                        pending_q      <= 1'b0;
                        tx_div_q       <= '0;
                        tx_tick_q      <= '0;
                        tx_line_q      <= 1'b0;
                        active_flag_tx <= 1'b1;
                        tx_state_q     <= ST_START;
                    end
                end
                ST_START: if (tx_bit_end_c) begin
                    tx_bit_q   <= '0;
                    tx_line_q  <= snap_data_c[0];
                    tx_state_q <= ST_DATA;
                end
                ST_DATA: if (tx_bit_end_c) begin
                    if (tx_bit_q == last_bit_c) begin
                        if (snap_par_c != 2'b00) begin
                            tx_line_q  <= tx_par_bit_c;
                            tx_state_q <= ST_PARITY;
                        end else begin
                            tx_line_q  <= 1'b1;
                            tx_stop_q  <= 1'b0;
                            tx_state_q <= ST_STOP;
                        end
                    end else begin
                        tx_bit_q  <= tx_next_bit_c;
                        tx_line_q <= snap_data_c[tx_next_bit_c];
                    end
                end
                ST_PARITY: if (tx_bit_end_c) begin
                    tx_line_q  <= 1'b1;
                    tx_stop_q  <= 1'b0;
                    tx_state_q <= ST_STOP;
                end
                ST_STOP: begin
                    if (tx_last_cyc_next_c && (tx_stop_q == snap_stop_c)) done_flag_tx <= 1'b1;
                    if (tx_bit_end_c) begin
                        if (tx_stop_q == snap_stop_c) begin
                            active_flag_tx <= 1'b0;
                            tx_state_q     <= ST_IDLE;
                        end else begin
                            tx_stop_q <= 1'b1;
                        end
                    end
                end
                default: tx_state_q <= ST_IDLE;
            endcase
        end
    end

    // Receiver FSM with line synchronizer
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q             <= ST_IDLE;
            rx_s1_q                <= 1'b1;
            rx_s2_q                <= 1'b1;
            rx_s3_q                <= 1'b1;
            rx_div_q               <= '0;
            rx_tick_q              <= '0;
            rx_bit_q               <= '0;
            rx_stop_q              <= 1'b0;
            rx_shift_q             <= '0;
            rx_par_err_q           <= 1'b0;
            rx_stop_err_q          <= 1'b0;
            data_received          <= '0;
            data_corrupted_flag    <= 1'b0;
            active_flag_rx         <= 1'b0;
            transmission_done_flag <= 1'b0;
        end else begin
            rx_s1_q                <= tx_line_q;
            rx_s2_q                <= rx_s1_q;
            rx_s3_q                <= rx_s2_q;
            transmission_done_flag <= 1'b0;
            if (rx_state_q != ST_IDLE) begin
                rx_div_q <= rx_tick_c ? '0 : rx_div_q + DIV_W'(1);
                if (rx_tick_c) rx_tick_q <= rx_sample_c ? 4'd0 : rx_tick_q + 4'd1;
            end
            case (rx_state_q)
                ST_IDLE: if (rx_fall_c) begin
                    rx_div_q       <= '0;
                    rx_tick_q      <= '0;
                    rx_shift_q     <= '0;
                    rx_par_err_q   <= 1'b0;
                    rx_stop_err_q  <= 1'b0;
                    active_flag_rx <= 1'b1;
                    rx_state_q     <= ST_START;
                end
                ST_START: if (rx_sample_c) begin
                    if (rx_s2_q) begin
                        active_flag_rx <= 1'b0;
                        rx_state_q     <= ST_IDLE;
                    end else begin
                        rx_bit_q   <= '0;
                        rx_state_q <= ST_DATA;
                    end
                end
                ST_DATA: if (rx_sample_c) begin
                    rx_shift_q[rx_bit_q] <= rx_s2_q;
                    if (rx_bit_q == last_bit_c) begin
                        rx_stop_q  <= 1'b0;
                        rx_state_q <= (snap_par_c != 2'b00) ? ST_PARITY : ST_STOP;
                    end else begin
                        rx_bit_q <= rx_bit_q + 3'd1;
                    end
                end
                ST_PARITY: if (rx_sample_c) begin
                    rx_par_err_q <= (rx_s2_q != rx_par_exp_c);
                    rx_state_q   <= ST_STOP;
                end
                ST_STOP: if (rx_sample_c) begin
                    if (rx_stop_q == snap_stop_c) begin
                        data_received          <= rx_shift_q;
                        data_corrupted_flag    <= rx_par_err_q | rx_stop_err_c;
                        transmission_done_flag <= 1'b1;
                        active_flag_rx         <= 1'b0;
                        rx_state_q             <= ST_IDLE;
                    end else begin
                        rx_stop_err_q <= rx_stop_err_c;
                        rx_stop_q     <= 1'b1;
                    end
                end
                default: rx_state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart.sv
// tb_uart: directed loopback checks of framing, timing, parity and reset.
module tb_uart;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] baud_sel;
    logic [4:0] line_control_reg;
    logic [7:0] data_input;
    logic [7:0] data_received;
    logic       data_corrupted_flag;
    logic       active_flag_rx;
    logic       transmission_done_flag;
    logic       active_flag_tx;
    logic       done_flag_tx;

    int checks = 0;
    int errors = 0;

    uart #(.CLK_HZ(18_432_000)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .baud_sel               (baud_sel),
        .line_control_reg       (line_control_reg),
        .data_input             (data_input),
        .data_received          (data_received),
        .data_corrupted_flag    (data_corrupted_flag),
        .active_flag_rx         (active_flag_rx),
        .transmission_done_flag (transmission_done_flag),
        .active_flag_tx         (active_flag_tx),
        .done_flag_tx           (done_flag_tx)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, ":data_received"}, 32'(data_received), 32'h0);
        check_eq({tag, ":corrupted"}, 32'(data_corrupted_flag), 32'h0);
        check_eq({tag, ":active_rx"}, 32'(active_flag_rx), 32'h0);
        check_eq({tag, ":rx_done"}, 32'(transmission_done_flag), 32'h0);
        check_eq({tag, ":active_tx"}, 32'(active_flag_tx), 32'h0);
        check_eq({tag, ":tx_done"}, 32'(done_flag_tx), 32'h0);
        check_eq({tag, ":line"}, 32'(dut.tx_line_q), 32'h1);
    endtask

    // Waits for a frame, measures its length and pulse placement, then checks RX results.
    // par_off < 0 means no parity bit is sampled.
    task automatic run_frame(input string tag, input int exp_len, input logic [7:0] exp_data,
                             input logic exp_corr, input int par_off, input logic exp_par);
        int wait_cyc = 0;
        int len = 0;
        int rx_cnt = 0;
        int tx_cnt = 0;
        int rx_at = -1;
        int tx_at = -1;
        logic par_seen = 1'bx;
        while (!active_flag_tx && wait_cyc < 200) begin
            step();
            wait_cyc++;
        end
        check_eq({tag, ":start"}, 32'(active_flag_tx), 32'h1);
        check_eq({tag, ":line_low"}, 32'(dut.tx_line_q), 32'h0);
        while (active_flag_tx && len < 40000) begin
            if (len == par_off) par_seen = dut.tx_line_q;
            if (transmission_done_flag) begin rx_cnt++; rx_at = len; end
            if (done_flag_tx) begin tx_cnt++; tx_at = len; end
            step();
            len++;
        end
        check_eq({tag, ":frame_len"}, 32'(len), 32'(exp_len));
        check_eq({tag, ":rx_pulses"}, 32'(rx_cnt), 32'h1);
        check_eq({tag, ":tx_pulses"}, 32'(tx_cnt), 32'h1);
        check_eq({tag, ":tx_done_last"}, 32'(tx_at), 32'(exp_len - 1));
        check_eq({tag, ":rx_before_tx"}, 32'(rx_at < tx_at && rx_at >= 0), 32'h1);
        check_eq({tag, ":data"}, 32'(data_received), 32'(exp_data));
        check_eq({tag, ":corrupted"}, 32'(data_corrupted_flag), 32'(exp_corr));
        check_eq({tag, ":active_rx_low"}, 32'(active_flag_rx), 32'h0);
        if (par_off >= 0) check_eq({tag, ":parity_bit"}, 32'(par_seen), 32'(exp_par));
    endtask

    initial begin
        rst              = 1'b1;
        baud_sel         = 2'b00;
        line_control_reg = 5'b00000;
        data_input       = 8'h7F;
        repeat (5) step();
        check_idle_zero("reset");
        rst = 1'b0;

        // 8N1 at 9600: 10 bits x 1920
        run_frame("rel_7F", 19200, 8'h7F, 1'b0, -1, 1'b0);

        // 8N1 at 19200
        baud_sel   = 2'b01;
        data_input = 8'hAA;
        run_frame("b1_AA", 9600, 8'hAA, 1'b0, -1, 1'b0);
        data_input = 8'h6D;
        run_frame("b1_6D", 9600, 8'h6D, 1'b0, -1, 1'b0);

        // 8-bit parity frames at 115200: 11 x 160, parity mid-bit at 9*160+80
        baud_sel         = 2'b11;
        line_control_reg = 5'b00001;
        data_input       = 8'h55;
        run_frame("odd_55", 1760, 8'h55, 1'b0, 1520, 1'b1);
        line_control_reg = 5'b00010;
        data_input       = 8'hE2;
        run_frame("even_E2", 1760, 8'hE2, 1'b0, 1520, 1'b0);
        line_control_reg = 5'b00011;
        run_frame("inj_E2", 1760, 8'hE2, 1'b1, 1520, 1'b1);
        line_control_reg = 5'b00000;
        data_input       = 8'h1D;
        run_frame("clr_1D", 1600, 8'h1D, 1'b0, -1, 1'b0);

        // 5-bit words, one then two stop bits
        line_control_reg = 5'b11000;
        data_input       = 8'hFF;
        run_frame("w5_FF", 1120, 8'h1F, 1'b0, -1, 1'b0);
        line_control_reg = 5'b11100;
        run_frame("w5s2_FF", 1280, 8'h1F, 1'b0, -1, 1'b0);

        // Reset in the middle of a frame, then a fresh frame from the pending flag
        line_control_reg = 5'b00000;
        data_input       = 8'h3C;
        begin
            int w = 0;
            while (!active_flag_tx && w < 200) begin step(); w++; end
        end
        check_eq("mid:started", 32'(active_flag_tx), 32'h1);
        repeat (500) step();
        rst = 1'b1;
        step();
        check_idle_zero("mid_rst");
        step();
        rst = 1'b0;
        run_frame("post_3C", 1600, 8'h3C, 1'b0, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart.md
# uart

Self-contained UART block: transmitter, receiver and 16x-oversampling baud generator in one clock domain. The serial line is looped back internally, with TX output driving RX input. It turns a parallel byte plus line configuration into a framed serial word, then recovers and checks it. It serves as a bring-up and self-test UART core: it exercises baud selection, word length, parity and stop-bit options, and reports receive integrity.

## Interface
Parameters:
- CLK_HZ, 18_432_000, system clock frequency; the divisors below assume this value.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, 18.432 MHz
- rst  in  1  synchronous active-high reset
- baud_sel  in  2  baud rate select: 00=9600 (div 120), 01=19200 (div 60), 10=38400 (div 30), 11=115200 (div 10); div = clk cycles per 16x tick
- line_control_reg  in  5  line configuration:
  - [1:0] parity: 00 none, 01 odd, 10 even, 11 even with the parity bit deliberately inverted on TX (error injection)
  - [2] stop bits: 0=1, 1=2
  - [4:3] word length: 00=8, 01=7, 10=6, 11=5
- data_input  in  8  word to send, LSB first; unused upper bits ignored
- data_received  out  8  last received word, right-aligned, upper bits zero
- data_corrupted_flag  out  1  last received frame had a parity or stop-bit error
- active_flag_rx  out  1  receiver inside a frame
- transmission_done_flag  out  1  1-cycle pulse: receive frame complete
- active_flag_tx  out  1  transmitter inside a frame
- done_flag_tx  out  1  1-cycle pulse: transmit frame complete

## Operation
- **TX trigger:**
  - A frame starts when TX is idle and {baud_sel, line_control_reg, data_input} differs from the snapshot taken at the last frame start.
  - A pending flag set by reset forces one frame after reset release.
  - Inputs that change mid-frame are not applied; a new frame starts after the current one ends if inputs differ from the snapshot.
- **Snapshot:** at frame start TX latches data, configuration and divisor. The tick counter restarts at frame start.
- **TX FSM states:** IDLE (line=1), START (0), DATA (N bits, LSB first), PARITY (only if parity≠00), STOP (1 or 2 bits of 1), then IDLE.
  - Each bit lasts 16 ticks.
  - done_flag_tx pulses on the last cycle of the final stop bit.
- **Parity:** computed over the N data bits. Even: the parity bit makes the total count of ones even. Odd: the total count of ones is odd. Mode 11 transmits the inverted even parity bit.
- **RX:**
  - Input passes through a 2-flop synchronizer; RX uses the TX-latched configuration and divisor.
  - IDLE: a falling edge moves to START.
  - START: samples at tick 8; if the line is high, returns to IDLE (glitch) with no flags.
  - DATA, PARITY and STOP bits are sampled at mid-bit (every 16 ticks after the start mid-point).
  - RX checks even parity for modes 10 and 11 and odd for 01; stop bits must be 1.
- **RX completion** (last stop-bit sample):
  - data_received is loaded.
  - data_corrupted_flag is set to (parity error OR stop error); it holds until the next completion.
  - transmission_done_flag pulses for 1 cycle.
  - active_flag_rx drops.
- active_flag_tx and active_flag_rx are high for the full frame in their FSMs.

## Timing
- Bit time = 16 × div clocks: 1920, 960, 480 or 160 cycles for baud_sel 00, 01, 10, 11.
- Frame length = (1 + N + P + S) bit times. Example: 8N1 at 9600 = 19200 cycles ≈ 1.042 ms.
- The TX line falls 1 cycle after the trigger condition is met; active_flag_tx rises in the same cycle.
- active_flag_rx rises 2–3 cycles after the TX line falls (synchronizer latency).
- transmission_done_flag occurs about half a bit time plus the synchronizer delay after the last stop bit starts, i.e. before done_flag_tx.
- Reset values: line=1; every output = 0; FSMs in IDLE; snapshot cleared; pending=1.
- Reset mid-frame aborts both FSMs within the reset cycle. No done pulses are produced.

## Test plan
- Reset release with data_input=8'h7F, lcr=00000, baud 00 → one frame of 19200 cycles; data_received=8'h7F, data_corrupted_flag=0, one pulse each of transmission_done_flag and done_flag_tx.
- data_input=8'hAA, then 8'h6D, lcr=00000 at baud 01 → data_received=8'hAA, then 8'h6D; frame = 9600 cycles.
- lcr=00001 (odd parity), data 8'h55 → line parity bit=1, data_received=8'h55, corrupted=0. lcr=00010 (even parity), data 8'hE2 → parity bit=0, corrupted=0.
- lcr=00011, data 8'hE2 → data_received=8'hE2, data_corrupted_flag=1. Next frame lcr=00000, data 8'h1D → flag clears to 0.
- lcr=11000 (5-bit word), data 8'hFF at baud 11 → data_received=8'h1F; frame = 7×160 = 1120 cycles. lcr bit 2 set → frame grows by 160 cycles.
- Assert rst mid-frame → all outputs 0, line high next cycle. After release, one fresh frame with the current inputs.
